garbage_insert: RTL and testbench

//  Inverse of the row-removal path: pushes the playfield UP by N rows and fills the vacated

---
 rtl/grid_pkg.sv | 45 ++++
 rtl/garbage_lfsr.sv | 38 +++
 rtl/garbage_insert.sv | 184 ++++++++++++++++++
 tb/tb_garbage_insert.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared playfield types for the grid datapath blocks (line clear, garbage insert).
// Row 0 is the top of the playfield and row 21 is the bottom; a cell value of 0 means empty.
package grid_pkg;

   localparam int GRID_ROWS = 22;
   localparam int GRID_COLS = 10;

   typedef logic [2:0]                cell_t;
   typedef cell_t [GRID_COLS-1:0]     row_t;
   typedef row_t  [GRID_ROWS-1:0]     grid_t;

   localparam cell_t CELL_EMPTY = 3'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } gi_state_t;

   // Fold a 4-bit raw LFSR nibble into a column index 0..9.
   function automatic logic [3:0] fold_hole(input logic [3:0] raw);
      logic [3:0] col;
      if (raw < 4'd10) begin
         col = raw;
      end else begin
         col = raw - 4'd10;
      end
      return col;
   endfunction

   // Solid garbage row of the given colour with a single empty cell at the hole column.
   function automatic row_t garbage_row(input logic [3:0] hole, input cell_t color);
      row_t row;
      for (int c = 0; c < GRID_COLS; c++) begin
         if (4'(c) == hole) begin
            row[c] = CELL_EMPTY;
         end else begin
            row[c] = color;
         end
      end
      return row;
   endfunction

endpackage

// File: rtl/garbage_lfsr.sv
// Hole column generator: free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) whose low
// nibble is folded into a column index 0..9. A non-zero seed keeps the LFSR out of the
// all-zero lock-up state.
module garbage_lfsr
   import grid_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] hole
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;
   logic       fb_s;

   // Next LFSR value: feedback from taps 8,6,5,4 shifted into the LSB.
   always_comb begin
      fb_s   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
      lfsr_d = {lfsr_q[6:0], fb_s};
   end

   // LFSR state; advances every cycle outside reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Column index presented to the inserter for the current cycle.
   always_comb begin
      hole = fold_hole(lfsr_q[3:0]);
   end

endmodule

// File: rtl/garbage_insert.sv
// Garbage row inserter: pushes the playfield up by N rows and fills the vacated bottom rows
// with solid garbage rows, each carrying one empty hole column.
// Optional build macro GARBAGE_SAME_HOLE_EN: when defined, one hole column is chosen per
// operation (sampled in CHECK) so all inserted rows line up into a vertical well; otherwise
// each garbage row takes a fresh hole from the LFSR.
module garbage_insert
   import grid_pkg::*;
#(
   parameter cell_t       GARBAGE_COLOR = 3'd7,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5,
   parameter int unsigned MAX_ROWS      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] count,
   input  grid_t      c_grid,
   output grid_t      n_grid,
   output logic       busy,
   output logic       done,
   output logic       topout
);

   localparam logic [4:0] MAX_N    = 5'(MAX_ROWS);
   localparam logic [4:0] LAST_ROW = 5'(GRID_ROWS - 1);

   gi_state_t  state_q, state_d;
   grid_t      buf_q, buf_d;
   logic [4:0] r_q, r_d;
   logic [4:0] n_q, n_d;
   logic       topout_q, topout_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [3:0] hole_s;
   logic [3:0] row_hole_s;
   logic [4:0] count_ext_s;
   logic [4:0] sat_n_s;
   logic [5:0] src_sum_s;
   logic [4:0] src_idx_s;
   logic       top_hit_s;

   garbage_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .hole (hole_s)
   );

`ifdef GARBAGE_SAME_HOLE_EN
   logic [3:0] keep_hole_q, keep_hole_d;

   // Capture one hole column during CHECK for the whole operation.
   always_comb begin
      if (state_q == CHECK) begin
         keep_hole_d = hole_s;
      end else begin
         keep_hole_d = keep_hole_q;
      end
   end

   // Per-operation hole register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         keep_hole_q <= 4'd0;
      end else begin
         keep_hole_q <= keep_hole_d;
      end
   end

   assign row_hole_s = keep_hole_q;
`else
   assign row_hole_s = hole_s;
`endif

   // Saturate the requested row count; count is widened before the compare.
   always_comb begin
      count_ext_s = {2'b00, count};
      if (count_ext_s > MAX_N) begin
         sat_n_s = MAX_N;
      end else begin
         sat_n_s = count_ext_s;
      end
   end

   // Source row for the upward shift; the 6-bit sum decides copy versus garbage fill.
   always_comb begin
      src_sum_s = {1'b0, r_q} + {1'b0, n_q};
      src_idx_s = r_q + n_q;
   end

   // Any occupied cell in the top N rows will be pushed off the playfield.
   always_comb begin
      top_hit_s = 1'b0;
      for (int i = 0; i < GRID_ROWS; i++) begin
         top_hit_s = top_hit_s | ((5'(i) < n_q) && (buf_q[i] != '0));
      end
   end

   // Controller: accept, top-out check, one row per cycle shift, completion pulse.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      r_d      = r_q;
      n_d      = n_q;
      topout_d = topout_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               buf_d    = c_grid;
               n_d      = sat_n_s;
               topout_d = 1'b0;
               r_d      = 5'd0;
               if (sat_n_s == 5'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = CHECK;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CHECK: begin
            topout_d = top_hit_s;
            r_d      = 5'd0;
            state_d  = SHIFT;
            busy_d   = 1'b1;
         end
         SHIFT: begin
            // Ascending row order reads each source row before it is overwritten.
            if (src_sum_s <= {1'b0, LAST_ROW}) begin
               buf_d[r_q] = buf_q[src_idx_s];
            end else begin
               buf_d[r_q] = garbage_row(row_hole_s, GARBAGE_COLOR);
            end
            if (r_q == LAST_ROW) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               r_d    = r_q + 5'd1;
               busy_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         r_q      <= 5'd0;
         n_q      <= 5'd0;
         topout_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         r_q      <= r_d;
         n_q      <= n_d;
         topout_q <= topout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign n_grid = buf_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign topout = topout_q;

endmodule

// File: tb/tb_garbage_insert.sv
// Directed bench for garbage_insert: a cycle-level reference model predicts done/busy timing
// and the final grid/topout of every accepted operation; a compare process checks them each
// cycle, and directed scenarios add hand-computed literal expectations.
module tb_garbage_insert;
   import grid_pkg::*;

   localparam logic [7:0] SEED  = 8'hA5;
   localparam int         MAXR  = 4;
   localparam cell_t      GCOL  = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] count = 3'd0;
   grid_t      c_grid = '0;
   grid_t      n_grid;
   logic       busy, done, topout;

   int checks = 0;
   int failures = 0;

   garbage_insert #(
      .GARBAGE_COLOR (GCOL),
      .LFSR_SEED     (SEED),
      .MAX_ROWS      (MAXR)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .count  (count),
      .c_grid (c_grid),
      .n_grid (n_grid),
      .busy   (busy),
      .done   (done),
      .topout (topout)
   );

   always #5 clk = ~clk;

   // ---------------- reference helpers ----------------
   function automatic logic [7:0] step8(input logic [7:0] v);
      logic fb;
      fb = ^(v & 8'b1011_1000);
      return {v[6:0], fb};
   endfunction

   function automatic logic [7:0] adv(input logic [7:0] v, input int k);
      logic [7:0] t;
      t = v;
      for (int i = 0; i < k; i++) t = step8(t);
      return t;
   endfunction

   function automatic int fold10(input logic [3:0] x);
      return int'(x) % 10;
   endfunction

   function automatic row_t gar(input int hole);
      row_t row;
      for (int c = 0; c < 10; c++) row[c] = (c == hole) ? 3'd0 : GCOL;
      return row;
   endfunction

   function automatic int sat(input logic [2:0] cnt);
      return (int'(cnt) > MAXR) ? MAXR : int'(cnt);
   endfunction

   // Final grid: rows move up by n; bottom n rows become garbage with holes taken from the
   // LFSR value of the cycle each row is written (cycle acc+2+r), or of CHECK (acc+1).
   function automatic grid_t build_exp(input grid_t g, input int n, input logic [7:0] l_acc);
      grid_t e;
      for (int r = 0; r < 22; r++) begin
         if (r + n <= 21) begin
            e[r] = g[r + n];
         end else begin
`ifdef GARBAGE_SAME_HOLE_EN
            e[r] = gar(fold10(adv(l_acc, 1) & 8'h0F));
`else
            e[r] = gar(fold10(adv(l_acc, 2 + r) & 8'h0F));
`endif
         end
      end
      return e;
   endfunction

   function automatic logic top_of(input grid_t g, input int n);
      logic t;
      t = 1'b0;
      for (int r = 0; r < n; r++) if (g[r] != '0) t = 1'b1;
      return t;
   endfunction

   function automatic logic is_garbage_row(input row_t row);
      int n7, n0;
      n7 = 0; n0 = 0;
      for (int c = 0; c < 10; c++) begin
         if (row[c] == GCOL) n7++;
         if (row[c] == 3'd0) n0++;
      end
      return (n7 == 9) && (n0 == 1);
   endfunction

   task automatic chk(input string nm, input logic [659:0] got, input logic [659:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // ---------------- cycle model ----------------
   int         cyc = 0;
   logic       m_active = 1'b0;
   int         m_acc = 0;
   int         m_done_cyc = 0;
   grid_t      m_grid = '0;
   logic       m_top = 1'b0;
   logic [7:0] m_lfsr = SEED;

   // Model: tracks LFSR value per cycle and predicts each accepted operation.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr   <= SEED;
         m_active <= 1'b0;
         m_grid   <= '0;
         m_top    <= 1'b0;
      end else begin
         m_lfsr <= step8(m_lfsr);
         cyc    <= cyc + 1;
         if (start && (!m_active || cyc > m_done_cyc)) begin
            m_active   <= 1'b1;
            m_acc      <= cyc;
            m_done_cyc <= cyc + ((sat(count) == 0) ? 1 : 24);
            m_grid     <= build_exp(c_grid, sat(count), m_lfsr);
            m_top      <= top_of(c_grid, sat(count));
         end
      end
   end

   // Compare: every cycle on the falling edge.
   always @(negedge clk) begin
      chk("done", 660'(done), 660'(m_active && (cyc == m_done_cyc)));
      chk("busy", 660'(busy), 660'(m_active && (cyc > m_acc) && (cyc < m_done_cyc)));
      if (!m_active || cyc >= m_done_cyc) begin
         chk("n_grid", n_grid, m_grid);
         chk("topout", 660'(topout), 660'(m_top));
      end
   end

   int done_cnt = 0;
   logic busy_seen = 1'b0;
   // Observation counters for the directed scenarios.
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_seen <= 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic start_op(input logic [2:0] cnt, input grid_t g);
      c_grid = g;
      count  = cnt;
      start  = 1'b1;
      step(1);
      start  = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #2;
      end
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout got=none exp=pulse");
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      grid_t g;
      int lat, ng;

      // Model pins (hand-computed LFSR steps from A5 and mod-10 fold).
      chk("pin_step0", 660'(step8(SEED)), 660'(8'h4A));
      chk("pin_step1", 660'(adv(SEED, 2)), 660'(8'h95));
      chk("pin_step2", 660'(adv(SEED, 3)), 660'(8'h2A));
      chk("pin_fold", 660'(fold10(4'hF)), 660'(5));

      step(2);
      rst = 1'b0;
      step(1);
      chk("rst_grid", n_grid, '0);
      chk("rst_flags", 660'({busy, done, topout}), 660'(3'b000));

      // 1: empty grid, two rows.
      start_op(3'd2, '0);
      wait_done(lat);
      chk("t1_latency", 660'(lat), 660'(24));
      chk("t1_upper_zero", 660'(n_grid[19:0]), 660'(0));
      chk("t1_row20", 660'(is_garbage_row(n_grid[20])), 660'(1));
      chk("t1_row21", 660'(is_garbage_row(n_grid[21])), 660'(1));
      chk("t1_topout", 660'(topout), 660'(0));

      // 2: bottom row of 1s moves up one.
      g = '0;
      g[21] = {10{3'd1}};
      start_op(3'd1, g);
      wait_done(lat);
      chk("t2_row20", 660'(n_grid[20]), 660'({10{3'd1}}));
      chk("t2_row21", 660'(is_garbage_row(n_grid[21])), 660'(1));
      chk("t2_topout", 660'(topout), 660'(0));

      // 3: occupied top row overflows.
      g = '0;
      g[0][4] = 3'd2;
      start_op(3'd1, g);
      wait_done(lat);
      chk("t3_topout", 660'(topout), 660'(1));
      chk("t3_rows_0_20", 660'(n_grid[20:0]), 660'(0));
      chk("t3_row21", 660'(is_garbage_row(n_grid[21])), 660'(1));

      // 4: count zero passes the grid through in one cycle.
      g = '0;
      g[21] = {10{3'd3}};
      g[5][0] = 3'd6;
      busy_seen = 1'b0;
      step(1);
      start_op(3'd0, g);
      wait_done(lat);
      chk("t4_latency", 660'(lat), 660'(1));
      chk("t4_grid", n_grid, g);
      chk("t4_busy_never", 660'(busy_seen), 660'(0));

      // 5a: count 7 saturates to 4; start re-pulsed mid-operation is ignored.
      g = '0;
      g[21] = {10{3'd1}};
      start_op(3'd7, g);
      step(4);
      c_grid = '1;
      count  = 3'd1;
      start  = 1'b1;
      step(1);
      start  = 1'b0;
      wait_done(lat);
      chk("t5_latency", 660'(lat + 5), 660'(24));
      ng = 0;
      for (int r = 0; r < 22; r++) if (is_garbage_row(n_grid[r])) ng++;
      chk("t5_garbage_rows", 660'(ng), 660'(4));
      chk("t5_row17", 660'(n_grid[17]), 660'({10{3'd1}}));
      done_cnt = 0;
      step(30);
      chk("t5_no_second_done", 660'(done_cnt), 660'(0));

      // 5b: reset in the middle of an operation.
      start_op(3'd3, g);
      step(9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      done_cnt = 0;
      step(1);
      chk("t5_rst_grid", n_grid, '0);
      step(40);
      chk("t5_rst_no_done", 660'(done_cnt), 660'(0));

      // 6: many operations checked cycle by cycle against the model.
      for (int i = 0; i < 200; i++) begin
         g = '0;
         for (int r = 12; r < 22; r++)
            for (int c = 0; c < 10; c++) g[r][c] = 3'($urandom_range(0, 7));
         if ((i % 7) == 0) g[1][3] = 3'd5;
         start_op(3'($urandom_range(0, 7)), g);
         wait_done(lat);
         for (int r = 22 - sat(count); r < 22; r++) begin
            if (!is_garbage_row(n_grid[r])) begin
               checks++;
               failures++;
               $display("FAIL hole_row op=%0d row=%0d got=%0h", i, r, n_grid[r]);
            end
`ifdef GARBAGE_SAME_HOLE_EN
            chk("same_hole", 660'(n_grid[r]), 660'(n_grid[21]));
`endif
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
